// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
// Used by the ALU top and by the result stage.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_SLT = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/result_mux8.sv
// Combinational 8:1 select of the ALU result bus named by the opcode.
// Every opcode is decoded, so the output is always defined.
module result_mux8
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [2:0]   sel,
  input  logic [W-1:0] in_and,
  input  logic [W-1:0] in_or,
  input  logic [W-1:0] in_xor,
  input  logic [W-1:0] in_not,
  input  logic [W-1:0] in_add,
  input  logic [W-1:0] in_sub,
  input  logic [W-1:0] in_slt,
  input  logic [W-1:0] in_mul,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (alu_op_e'(sel))
      OP_AND: y = in_and;
      OP_OR:  y = in_or;
      OP_XOR: y = in_xor;
      OP_NOT: y = in_not;
      OP_ADD: y = in_add;
      OP_SUB: y = in_sub;
      OP_SLT: y = in_slt;
      OP_MUL: y = in_mul;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects the op result, tags it with zero/sign flags
// and buffers it in a 2-entry valid/ready FIFO with a pop counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] res_and,
  input  logic [W-1:0] res_or,
  input  logic [W-1:0] res_xor,
  input  logic [W-1:0] res_not,
  input  logic [W-1:0] res_add,
  input  logic [W-1:0] res_sub,
  input  logic [W-1:0] res_slt,
  input  logic [W-1:0] res_mul,
  input  logic [2:0]   op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_op,
  output logic         out_zero,
  output logic         out_neg,
  output logic [15:0]  result_count
);

  logic [W-1:0] sel_res;

  logic [1:0]   cnt_q, cnt_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [15:0]  count_q, count_d;
  logic [W-1:0] res_q  [2];
  logic [W-1:0] res_d  [2];
  logic [2:0]   op_q   [2];
  logic [2:0]   op_d   [2];
  logic         zero_q [2];
  logic         zero_d [2];
  logic         neg_q  [2];
  logic         neg_d  [2];

  logic push;
  logic pop;

  result_mux8 #(.W(W)) u_mux (
    .sel    (op),
    .in_and (res_and),
    .in_or  (res_or),
    .in_xor (res_xor),
    .in_not (res_not),
    .in_add (res_add),
    .in_sub (res_sub),
    .in_slt (res_slt),
    .in_mul (res_mul),
    .y      (sel_res)
  );

  // Ready comes from occupancy only, so no path from out_ready.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    res_d    = res_q;
    op_d     = op_q;
    zero_d   = zero_q;
    neg_d    = neg_q;

    if (push) begin
      res_d[wr_ptr_q]  = sel_res;
      op_d[wr_ptr_q]   = op;
      zero_d[wr_ptr_q] = (sel_res == '0);
      neg_d[wr_ptr_q]  = sel_res[W-1];
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      count_d  = count_q + 16'd1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      res_q    <= '{default: '0};
      op_q     <= '{default: '0};
      zero_q   <= '{default: 1'b0};
      neg_q    <= '{default: 1'b0};
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      res_q    <= res_d;
      op_q     <= op_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign out_result   = res_q[rd_ptr_q];
  assign out_op       = op_q[rd_ptr_q];
  assign out_zero     = zero_q[rd_ptr_q];
  assign out_neg      = neg_q[rd_ptr_q];
  assign result_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: the driver queues expected
// entries, a negedge monitor pops and compares on each handshake.
module tb_alu_result_stage;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    logic        zero;
    logic        neg;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] res_and, res_or, res_xor, res_not;
  logic [31:0] res_add, res_sub, res_slt, res_mul;
  logic [2:0]  op;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_op;
  logic        out_zero;
  logic        out_neg;
  logic [15:0] result_count;

  ent_t        sb[$];
  int          compared;
  int          mismatched;
  int          mcnt;
  logic [15:0] exp_rc;

  alu_result_stage #(.W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .res_and      (res_and),
    .res_or       (res_or),
    .res_xor      (res_xor),
    .res_not      (res_not),
    .res_add      (res_add),
    .res_sub      (res_sub),
    .res_slt      (res_slt),
    .res_mul      (res_mul),
    .op           (op),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_op       (out_op),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
    .result_count (result_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pops on each DUT handshake; the entry was queued by the driver.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL mon_empty: got pop expected none");
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("mon_result", out_result, e.res);
        chk("mon_op", {29'd0, out_op}, {29'd0, e.op});
        chk("mon_zero", {31'd0, out_zero}, {31'd0, e.zero});
        chk("mon_neg", {31'd0, out_neg}, {31'd0, e.neg});
      end
    end
  end

  // Drives one cycle; the selected bus carries val, the others decoys.
  task automatic cyc(input logic vi, input logic [2:0] o,
                     input logic [31:0] val, input logic ordy);
    logic [31:0] b[8];
    bit acc;
    bit pp;
    ent_t e;
    for (int i = 0; i < 8; i++)
      b[i] = (i == int'(o)) ? val : (32'hDEAD_0000 | i);
    res_and = b[0]; res_or  = b[1]; res_xor = b[2]; res_not = b[3];
    res_add = b[4]; res_sub = b[5]; res_slt = b[6]; res_mul = b[7];
    op        = o;
    in_valid  = vi;
    out_ready = ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, mcnt < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mcnt > 0});
    chk("result_count", {16'd0, result_count}, {16'd0, exp_rc});
    if (mcnt > 0 && sb.size() > 0) begin
      chk("head_result", out_result, sb[0].res);
      chk("head_zero", {31'd0, out_zero}, {31'd0, sb[0].zero});
    end
    acc = vi && (mcnt < 2);
    pp  = ordy && (mcnt > 0);
    if (acc) begin
      e.res  = val;
      e.op   = o;
      e.zero = (val == 32'd0);
      e.neg  = val[31];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    mcnt = mcnt + int'(acc) - int'(pp);
    if (pp) exp_rc = exp_rc + 16'd1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    mcnt   = 0;
    exp_rc = 16'd0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_op", {29'd0, out_op}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_out_neg", {31'd0, out_neg}, 32'd0);
    chk("rst_count", {16'd0, result_count}, 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mcnt       = 0;
    exp_rc     = 16'd0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    op         = 3'd0;
    res_and = '0; res_or  = '0; res_xor = '0; res_not = '0;
    res_add = '0; res_sub = '0; res_slt = '0; res_mul = '0;
    @(posedge clk);
    #1;
    do_reset();

    // NOT result with sign bit set, popped right away
    cyc(1'b1, 3'd3, 32'hFFFF_FFF0, 1'b1);
    chk("lat1_valid", {31'd0, out_valid}, 32'd1);
    chk("lat1_neg", {31'd0, out_neg}, 32'd1);
    chk("lat1_zero", {31'd0, out_zero}, 32'd0);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 1'b0);
    chk("count_after_pop", {16'd0, result_count}, 32'd1);

    // ADD of zero held under backpressure
    cyc(1'b1, 3'd4, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_zero", {31'd0, out_zero}, 32'd1);
      chk("hold_op", {29'd0, out_op}, 32'd4);
      cyc(1'b0, 3'd0, 32'd0, 1'b0);
    end
    cyc(1'b0, 3'd0, 32'd0, 1'b1);

    // Fill to two, third push dropped, drain, then pop on empty
    cyc(1'b1, 3'd0, 32'd1, 1'b0);
    cyc(1'b1, 3'd1, 32'd2, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 3'd2, 32'd3, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 1'b0);
    chk("drain_count", {16'd0, result_count}, 32'd4);

    // Simultaneous push and pop with one entry held
    cyc(1'b1, 3'd6, 32'd9, 1'b0);
    cyc(1'b1, 3'd5, 32'd7, 1'b1);
    chk("pp_result", out_result, 32'd7);
    chk("pp_valid", {31'd0, out_valid}, 32'd1);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);

    // Stream push+pop until the pop counter wraps
    for (int i = 0; i < 70000 && exp_rc != 16'hFFFF; i++)
      cyc(1'b1, 3'd7, i, 1'b1);
    chk("count_ffff", {16'd0, result_count}, 32'h0000_FFFF);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 1'b0);
    chk("count_wrap", {16'd0, result_count}, 32'd0);
    while (mcnt > 0) cyc(1'b0, 3'd0, 32'd0, 1'b1);

    // Reset with two entries held discards them
    cyc(1'b1, 3'd0, 32'd5, 1'b0);
    cyc(1'b1, 3'd1, 32'h8000_0006, 1'b0);
    do_reset();

    // Stage operates normally after the mid-run reset
    cyc(1'b1, 3'd2, 32'h1234_5678, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 1'b0);
    chk("post_rst_count", {16'd0, result_count}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
